// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller.
//   SIZE_* : req_size encodings (byte/half/word/reserved)
//   ST_*   : controller FSM state encodings
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for little-endian sub-word accesses.
//   word     : word read from RAM
//   wdata    : right-justified store data
//   lane     : byte address bits [1:0]
//   size     : access size (mem_pkg SIZE_*)
//   sign_ext : 1 = sign-extend loaded byte/half, 0 = zero-extend
//   rdata    : extracted and extended load result
//   merged   : read word with the addressed byte(s) replaced by wdata
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        case (size)
            SIZE_BYTE: rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:   rdata = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the CPU memory stage and a single-port word RAM
// (async read, sync write). One request in flight; sub-word stores use
// read-modify-write; misaligned, out-of-range and reserved-size requests fault
// without touching the RAM.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we/size/signed  : store flag, access size, load extension
//   req_addr/req_wdata  : byte address, right-justified store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata/rsp_fault : load data (0 for stores/faults), fault flag
//   ram_addr/din/we     : RAM word address, write word, write enable
//   ram_dout            : RAM async read data
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout
);

    logic [1:0]        state;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    // Only the bits addressing the RAM are kept; higher bits are range-checked on accept.
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       ext_data;
    logic [31:0]       merged_data;
    logic              acc_fault;

    mem_lane_align u_align (
        .word     (ram_dout),
        .wdata    (wdata_q),
        .lane     (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .rdata    (ext_data),
        .merged   (merged_data)
    );

    always_comb begin
        acc_fault = 1'b0;
        if (req_size == SIZE_RSVD)                          acc_fault = 1'b1;
        if (req_size == SIZE_HALF && req_addr[0])           acc_fault = 1'b1;
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) acc_fault = 1'b1;
        if (req_addr[31:ADDR_W+2] != '0)                    acc_fault = 1'b1;
    end

    assign req_ready = rst_n & (state == ST_IDLE);
    // Gated by rst_n so a reset landing in WR never commits the write.
    assign ram_we    = rst_n & (state == ST_WR);
    assign ram_addr  = addr_q[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= SIZE_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            ram_din   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        addr_q   <= req_addr[ADDR_W+1:0];
                        wdata_q  <= req_wdata;
                        if (acc_fault) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_fault <= 1'b1;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        ram_din <= merged_data;
                        state   <= ST_WR;
                    end else begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ext_data;
                        rsp_fault <= 1'b0;
                    end
                end
                ST_WR: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_fault <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a word RAM model,
// a behavioural reference memory and an every-cycle response/write compare.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    // RAM attached to the DUT, plus a backdoor port for preloading.
    logic [31:0] ram     [0:1023];
    logic [31:0] mem_ref [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    assign ram_dout = ram[ram_addr];
    always @(posedge clk) begin
        if (bd_we)       ram[bd_addr]  <= bd_data;
        else if (ram_we) ram[ram_addr] <= ram_din;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_fault(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
        if ((addr >> (ADDR_W + 2)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sgn);
        int unsigned sh;
        logic [31:0] r;
        sh = 8 * int'(lane);
        r  = word >> sh;
        if (size == 2'd0) begin
            r = r & 32'h0000_00FF;
            if (sgn && r >= 32'h80) r = r | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            r = r & 32'h0000_FFFF;
            if (sgn && r >= 32'h8000) r = r | 32'hFFFF_0000;
        end else begin
            r = word;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
        int unsigned sh;
        logic [31:0] mask;
        sh = 8 * int'(lane);
        if (size == 2'd0)      mask = 32'h0000_00FF << sh;
        else if (size == 2'd1) mask = 32'h0000_FFFF << sh;
        else                   mask = 32'hFFFF_FFFF;
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    typedef struct { int unsigned due; logic [31:0] rdata; logic fault; } rsp_t;
    typedef struct { int unsigned due; logic [9:0] addr; logic [31:0] data; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    logic        started = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_fault = 1'b0;
    int unsigned last_cyc = 0;
    logic        ev, ew;

    // Every-cycle compare of response pulses and RAM writes against the model queues.
    always @(negedge clk) begin
        if (started) begin
            ev = (rq.size() > 0) && (rq[0].due == cyc);
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, rq[0].rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(rq[0].fault));
                last_rdata = rsp_rdata;
                last_fault = rsp_fault;
                last_cyc   = cyc;
                rq.delete(0);
            end else if (rq.size() > 0 && rq[0].due < cyc) begin
                rq.delete(0);
            end
            ew = (wq.size() > 0) && (wq[0].due == cyc);
            chk("ram_we", 32'(ram_we), 32'(ew));
            if (ew) begin
                chk("ram_addr", 32'(ram_addr), 32'(wq[0].addr));
                chk("ram_din", ram_din, wq[0].data);
                wq.delete(0);
            end else if (wq.size() > 0 && wq[0].due < cyc) begin
                wq.delete(0);
            end
        end
    end

    task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we      = 1'b0;
        mem_ref[a] = d;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int unsigned acc);
        int unsigned due;
        logic [9:0]  widx;
        logic [31:0] nw;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        acc  = cyc;
        widx = addr[11:2];
        if (ref_fault(size, addr)) begin
            due = acc;
            rq.push_back('{due, 32'h0, 1'b1});
        end else if (!we) begin
            due = acc + 1;
            rq.push_back('{due, ref_load(mem_ref[widx], addr[1:0], size, sgn), 1'b0});
        end else begin
            nw = ref_store(mem_ref[widx], wdata, addr[1:0], size);
            wq.push_back('{acc + 1, widx, nw});
            mem_ref[widx] = nw;
            due = acc + 2;
            rq.push_back('{due, 32'h0, 1'b0});
        end
        // Junk requests while busy must be ignored.
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        do begin
            @(negedge clk);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
        end while (cyc < due);
        req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned a;
        int          bad;
        logic [1:0]  sz;
        logic [31:0] ad;
        int unsigned sel;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        // Preload RAM while reset is held.
        for (int i = 0; i < 1024; i++) begin
            bd_addr = 10'(i);
            bd_data = $urandom;
            mem_ref[i] = bd_data;
            bd_we = 1'b1;
            @(posedge clk);
            #1;
        end
        bd_we = 1'b0;

        // 1. reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        started = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        // 2. word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, a);
        @(posedge clk); #1;
        chk("t2_store_latency", last_cyc - a + 1, 32'd3);
        chk("t2_ram4", ram[4], 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a);
        @(posedge clk); #1;
        chk("t2_load_latency", last_cyc - a + 1, 32'd2);
        chk("t2_load_data", last_rdata, 32'hDEAD_BEEF);

        // 3. byte store RMW and signed/unsigned byte loads
        bd_write(10'd0, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h3, 32'h0000_00AA, a);
        @(posedge clk); #1;
        chk("t3_ram0", ram[0], 32'hAA22_3344);
        do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, a);
        @(posedge clk); #1;
        chk("t3_lb_signed", last_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, a);
        @(posedge clk); #1;
        chk("t3_lb_unsigned", last_rdata, 32'h0000_00AA);

        // 4. signed half loads
        bd_write(10'd0, 32'h8001_7FFF);
        do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, a);
        @(posedge clk); #1;
        chk("t4_lh_hi", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, a);
        @(posedge clk); #1;
        chk("t4_lh_lo", last_rdata, 32'h0000_7FFF);

        // 5. faults (as stores, so any RAM write would be visible)
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin sz = 2'd1; ad = 32'h1;    end
                1: begin sz = 2'd2; ad = 32'h2;    end
                2: begin sz = 2'd3; ad = 32'h0;    end
                default: begin sz = 2'd2; ad = 32'h1000; end
            endcase
            do_req(1'b1, sz, 1'b0, ad, 32'hCAFE_F00D, a);
            @(posedge clk); #1;
            chk("t5_fault_flag", 32'(last_fault), 32'd1);
            chk("t5_fault_rdata", last_rdata, 32'd0);
            chk("t5_fault_latency", last_cyc - a + 1, 32'd1);
        end
        chk("t5_ram0_unchanged", ram[0], 32'h8001_7FFF);

        // 6. reset during the WR cycle of a store
        @(negedge clk);
        chk("t6_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_we_in_reset", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("t6_ram8_unchanged", ram[8], mem_ref[8]);
        chk("t6_idle_after", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            sz  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            if (sel < 6)       ad = 32'($urandom_range(0, 63));
            else if (sel == 6) ad = 32'($urandom_range(0, 4095));
            else               ad = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, a);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;

        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== mem_ref[i]) bad++;
        chk("final_ram_scan_mismatches", 32'(bad), 32'd0);
        chk("queues_drained", 32'(rq.size() + wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
